// File: rtl/skewed_input_feeder.sv
// -----------------------------------------------------------------------------
// skewed_input_feeder
//
// Collects a tile of DEPTH input vectors (LANES elements of DATA_W bits each)
// and, on request, streams it out with a per-lane time skew so that lane i
// starts i*LANE_DELAY cycles after lane 0. This is the classic diagonal
// wavefront needed to feed the rows of a systolic array.
//
// Operation:
//   IDLE/LOAD : accept vectors over a valid/ready handshake into the buffer.
//   FULL      : tile is complete; wait for a single-cycle start pulse.
//   STREAM    : run the stream counter s over 0..L-1, where
//               L = DEPTH + (LANES-1)*LANE_DELAY, then return to IDLE.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data carries a vector
//   in_ready   out  block can accept a vector (IDLE or LOAD)
//   in_data    in   LANES*DATA_W, lane i at [i*DATA_W +: DATA_W]
//   start      in   request streaming of the stored tile (only honoured in FULL)
//   full       out  tile loaded and waiting for start
//   out_data   out  skewed lane outputs, packed like in_data (registered)
//   out_valid  out  per-lane valid for out_data (registered)
//   done       out  one-cycle pulse on the last stream cycle (registered)
// -----------------------------------------------------------------------------
module skewed_input_feeder #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int DEPTH      = 8,
    parameter int LANE_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    input  logic                     start,
    output logic                     full,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic [LANES-1:0]         out_valid,
    output logic                     done
);

    localparam int STREAM_LEN = DEPTH + (LANES - 1) * LANE_DELAY;
    localparam int WR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int S_W        = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;

    localparam logic [WR_W-1:0] WR_LAST = WR_W'(DEPTH - 1);
    localparam logic [S_W-1:0]  S_LAST  = S_W'(STREAM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL,
        STREAM
    } state_t;

    state_t                    state, state_next;
    logic [WR_W-1:0]           wr_cnt, wr_cnt_next;
    logic [S_W-1:0]            s_cnt, s_cnt_next;
    logic                      accept;

    logic [LANES*DATA_W-1:0]   buf_mem [DEPTH];

    logic [LANES*DATA_W-1:0]   out_data_next;
    logic [LANES-1:0]          out_valid_next;
    logic                      done_next;

    // Handshake and status are pure state decodes so they never depend on
    // in_valid or start in the same cycle.
    assign in_ready = (state == IDLE) || (state == LOAD);
    assign full     = (state == FULL);
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state / counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next  = state;
        wr_cnt_next = wr_cnt;
        s_cnt_next  = s_cnt;

        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (wr_cnt == WR_LAST) begin
                        state_next  = FULL;
                        wr_cnt_next = '0;
                    end else begin
                        state_next  = LOAD;
                        wr_cnt_next = wr_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    state_next = STREAM;
                    s_cnt_next = '0;
                end
            end
            STREAM: begin
                if (s_cnt == S_LAST) begin
                    state_next = IDLE;
                    s_cnt_next = '0;
                end else begin
                    s_cnt_next = s_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output pre-computation. The outputs are registered, so they are derived
    // from the *next* state and stream index: the edge that samples start
    // already loads the s=0 wavefront, making lane 0 valid in the first
    // STREAM cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        int k;
        k              = 0;
        out_data_next  = '0;
        out_valid_next = '0;
        done_next      = 1'b0;

        if (state_next == STREAM) begin
            done_next = (s_cnt_next == S_LAST);
            for (int i = 0; i < LANES; i++) begin
                // k is the vector index lane i should present at this s.
                k = int'(s_cnt_next) - i * LANE_DELAY;
                if (k >= 0 && k < DEPTH) begin
                    out_valid_next[i]                  = 1'b1;
                    out_data_next[i*DATA_W +: DATA_W]  =
                        buf_mem[WR_W'(k)][i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            s_cnt     <= '0;
            out_data  <= '0;
            out_valid <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            wr_cnt    <= wr_cnt_next;
            s_cnt     <= s_cnt_next;
            out_data  <= out_data_next;
            out_valid <= out_valid_next;
            done      <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Tile buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer has no reset; every entry is written before it is read
    // in a tile, and leaving it unreset lets it map onto RAM/register-file
    // primitives. Writes are blocked during reset so a discarded beat cannot
    // land.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            buf_mem[wr_cnt] <= in_data;
        end
    end

endmodule

// File: tb/tb_skewed_input_feeder.sv
// -----------------------------------------------------------------------------
// tb_skewed_input_feeder
//
// Self-checking bench for skewed_input_feeder. dut_skew uses LANE_DELAY=1,
// dut_flat uses LANE_DELAY=0 (LANES=4, DEPTH=4, DATA_W=8 for both).
// Stimulus is driven on the falling edge; outputs are sampled on the falling
// edge before the next inputs are applied. Expected stream frames are built
// from a reference copy of the loaded tile and queued when start is driven,
// then popped one per stream cycle.
// -----------------------------------------------------------------------------
module tb_skewed_input_feeder;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int VEC_W  = LANES * DATA_W;

    typedef struct {
        logic [LANES-1:0] valid;
        logic [VEC_W-1:0] data;
        logic             done;
    } frame_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [VEC_W-1:0] in_data;
    logic             start;
    logic             in_ready;
    logic             full;
    logic [VEC_W-1:0] out_data;
    logic [LANES-1:0] out_valid;
    logic             done;

    logic             in_valid_flat;
    logic             start_flat;
    logic             in_ready_flat;
    logic             full_flat;
    logic [VEC_W-1:0] out_data_flat;
    logic [LANES-1:0] out_valid_flat;
    logic             done_flat;

    int               n_checks;
    int               n_errors;
    logic [VEC_W-1:0] exp_mem [DEPTH];
    frame_t           sb_q [$];

    skewed_input_feeder #(
        .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .LANE_DELAY(1)
    ) dut_skew (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start(start), .full(full),
        .out_data(out_data), .out_valid(out_valid), .done(done)
    );

    skewed_input_feeder #(
        .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .LANE_DELAY(0)
    ) dut_flat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_flat), .in_ready(in_ready_flat), .in_data(in_data),
        .start(start_flat), .full(full_flat),
        .out_data(out_data_flat), .out_valid(out_valid_flat), .done(done_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end within time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lane i of vector v = base + 0x10*v + i.
    function automatic logic [VEC_W-1:0] make_vec(input int base, input int v);
        logic [VEC_W-1:0] vec;
        vec = '0;
        for (int i = 0; i < LANES; i++)
            vec[i*DATA_W +: DATA_W] = DATA_W'(base + 16 * v + i);
        return vec;
    endfunction

    // Expected stream for the tile in exp_mem with the given lane delay.
    task automatic push_frames(input int ld);
        int     len;
        int     k;
        frame_t f;
        len = DEPTH + (LANES - 1) * ld;
        for (int s = 0; s < len; s++) begin
            f.valid = '0;
            f.data  = '0;
            f.done  = (s == len - 1);
            for (int i = 0; i < LANES; i++) begin
                k = s - i * ld;
                if (k >= 0 && k < DEPTH) begin
                    f.valid[i]                 = 1'b1;
                    f.data[i*DATA_W +: DATA_W] = exp_mem[k][i*DATA_W +: DATA_W];
                end
            end
            sb_q.push_back(f);
        end
    endtask

    // Called at a falling edge with the DUT ready; returns at the falling edge
    // where FULL is first visible. gap inserts an idle cycle with junk data
    // between beats; start_at pulses start before that beat index.
    task automatic load_tile(input int base, input bit gap, input int start_at);
        for (int v = 0; v < DEPTH; v++) begin
            if (v == start_at) begin
                start    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                start = 1'b0;
                check("start_in_load_full", 64'(full), 64'd0);
                check("start_in_load_ready", 64'(in_ready), 64'd1);
            end
            check("load_ready", 64'(in_ready), 64'd1);
            check("load_full_low", 64'(full), 64'd0);
            in_valid   = 1'b1;
            in_data    = make_vec(base, v);
            exp_mem[v] = make_vec(base, v);
            @(negedge clk);
            if (gap && v < DEPTH - 1) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                check("gap_ready", 64'(in_ready), 64'd1);
                check("gap_full_low", 64'(full), 64'd0);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check("loaded_full", 64'(full), 64'd1);
        check("loaded_ready_low", 64'(in_ready), 64'd0);
        check("loaded_out_valid", 64'(out_valid), 64'd0);
    endtask

    // Called at a falling edge in FULL. junk drives in_valid with garbage
    // throughout FULL and STREAM; abort_at asserts rst in that stream cycle.
    task automatic stream_tile(input bit junk, input int abort_at);
        frame_t f;
        int     len;
        len = DEPTH + (LANES - 1);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 32'hEEEE_EEEE;
            @(negedge clk);
            check("full_hold", 64'(full), 64'd1);
            check("full_hold_ready", 64'(in_ready), 64'd0);
        end
        check("full_before_start", 64'(full), 64'd1);
        start = 1'b1;
        push_frames(1);
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < len; s++) begin
            f = sb_q.pop_front();
            check($sformatf("s%0d_valid", s), 64'(out_valid), 64'(f.valid));
            check($sformatf("s%0d_data", s), 64'(out_data), 64'(f.data));
            check($sformatf("s%0d_done", s), 64'(done), 64'(f.done));
            check($sformatf("s%0d_ready", s), 64'(in_ready), 64'd0);
            check($sformatf("s%0d_full", s), 64'(full), 64'd0);
            if (s == abort_at) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check("abort_out_valid", 64'(out_valid), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_ready", 64'(in_ready), 64'd1);
                check("abort_full", 64'(full), 64'd0);
                rst = 1'b0;
                sb_q.delete();
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("post_done_ready", 64'(in_ready), 64'd1);
        check("post_done_valid", 64'(out_valid), 64'd0);
        check("post_done_done", 64'(done), 64'd0);
        check("post_done_full", 64'(full), 64'd0);
    endtask

    initial begin
        frame_t f;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        start         = 1'b0;
        in_valid_flat = 1'b0;
        start_flat    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flat_valid", 64'(out_valid_flat), 64'd0);
        rst = 1'b0;

        // Back-to-back load, then skewed stream (lane i = 0x10*k + i).
        load_tile(0, 1'b0, -1);
        stream_tile(1'b0, -1);

        // in_valid toggling with junk in the gaps; reload right after done.
        load_tile(8'h05, 1'b1, -1);
        stream_tile(1'b0, -1);

        // start during LOAD and in_valid during FULL/STREAM are ignored.
        load_tile(8'h0A, 1'b0, 2);
        stream_tile(1'b1, -1);

        // Reset in mid-stream, then a fresh tile.
        load_tile(8'h0C, 1'b0, -1);
        stream_tile(1'b0, 3);
        load_tile(8'h07, 1'b0, -1);
        stream_tile(1'b0, -1);
        load_tile(8'h01, 1'b1, -1);
        stream_tile(1'b0, -1);

        // LANE_DELAY = 0: all lanes together for s = 0..3, L = 4.
        for (int v = 0; v < DEPTH; v++) begin
            check("flat_ready", 64'(in_ready_flat), 64'd1);
            in_valid_flat = 1'b1;
            in_data       = make_vec(8'h02, v);
            exp_mem[v]    = make_vec(8'h02, v);
            @(negedge clk);
        end
        in_valid_flat = 1'b0;
        check("flat_full", 64'(full_flat), 64'd1);
        start_flat = 1'b1;
        push_frames(0);
        @(negedge clk);
        start_flat = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            f = sb_q.pop_front();
            check($sformatf("flat_s%0d_valid", s), 64'(out_valid_flat), 64'(f.valid));
            check($sformatf("flat_s%0d_data", s), 64'(out_data_flat), 64'(f.data));
            check($sformatf("flat_s%0d_done", s), 64'(done_flat), 64'(f.done));
            @(negedge clk);
        end
        check("flat_end_valid", 64'(out_valid_flat), 64'd0);
        check("flat_end_ready", 64'(in_ready_flat), 64'd1);
        check("flat_end_done", 64'(done_flat), 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
